// File: rtl/enc_frame_tx_pkg.sv
// +----------------------------------------------------------------------+
// | enc_frame_tx_pkg : shared state encoding and framing symbols          |
// | Optional feature macro: ENC_FRAME_PARITY_EN                           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package enc_frame_tx_pkg;

   localparam logic [1:0] c_HDR0_SYM     = 2'b00;
   localparam logic [1:0] c_HDR1_SYM     = 2'b01;
   localparam logic [1:0] c_IDLE_SYM_DEF = 2'b11;
   localparam int         c_CNT_W        = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR0    = 3'd1,
      ST_HDR1    = 3'd2,
      ST_PAYLOAD = 3'd3,
`ifdef ENC_FRAME_PARITY_EN
      ST_PARITY  = 3'd4,
`endif
      ST_DONE    = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/enc_frame_tx_if.sv
// +----------------------------------------------------------------------+
// | enc_frame_tx_if : request / payload / framed-output bundle            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface enc_frame_tx_if;
   logic       i_start;
   logic [7:0] i_key;
   logic [1:0] i_din;
   logic       i_din_valid;
   logic       o_din_ready;
   logic [1:0] o_out;
   logic       o_out_valid;
   logic       o_busy;
   logic       o_done;

   modport master (
      output i_start, i_key, i_din, i_din_valid,
      input  o_din_ready, o_out, o_out_valid, o_busy, o_done
   );

   modport slave (
      input  i_start, i_key, i_din, i_din_valid,
      output o_din_ready, o_out, o_out_valid, o_busy, o_done
   );
endinterface

`default_nettype wire

// File: rtl/enc_frame_tx_key_rotator.sv
// +----------------------------------------------------------------------+
// | key_rotator : 8-bit key register, load or rotate right by 2,          |
// | exposing the current 2-bit key symbol.   Rev 1.0                      |
// +----------------------------------------------------------------------+
`default_nettype none

module key_rotator
   import enc_frame_tx_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic       i_load,
   input  wire logic [7:0] i_key,
   input  wire logic       i_rot,
   output logic      [1:0] o_sym
);

   logic [7:0] r_key;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_key <= '0;
      end else if (i_load) begin
         r_key <= i_key;
      end else if (i_rot) begin
         r_key <= {r_key[1:0], r_key[7:2]};
      end
   end

   assign o_sym = r_key[1:0];

endmodule

`default_nettype wire

// File: rtl/enc_frame_tx.sv
// +----------------------------------------------------------------------+
// | enc_frame_tx : header + XOR-ciphered payload framer, registered out.  |
// | Optional parity trailer: ENC_FRAME_PARITY_EN.   Rev 1.0               |
// +----------------------------------------------------------------------+
`default_nettype none

module enc_frame_tx
   import enc_frame_tx_pkg::*;
#(
   parameter int         PAYLOAD_LEN = 8,
   parameter logic [1:0] IDLE_SYM    = c_IDLE_SYM_DEF
)
(
   input wire logic      clk,
   input wire logic      rst_n,
   enc_frame_tx_if.slave io_bus
);

   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PAYLOAD_LEN - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [1:0]         w_key_sym;
   logic               w_load;
   logic               w_accept;
   logic [1:0]         w_out;
   logic               w_out_valid;
   logic               w_done;
   logic [1:0]         r_out;
   logic               r_out_valid;
   logic               r_din_ready;
   logic               r_busy;
   logic               r_done;
`ifdef ENC_FRAME_PARITY_EN
   logic [1:0]         r_parity;
`endif

   key_rotator u_key_rotator (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_key  (io_bus.i_key),
      .i_rot  (w_accept),
      .o_sym  (w_key_sym)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_accept    = 1'b0;
      w_out       = IDLE_SYM;
      w_out_valid = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.i_start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_HDR0;
            end
         end
         ST_HDR0: begin
            w_out       = c_HDR0_SYM;
            w_out_valid = 1'b1;
            w_state_nxt = ST_HDR1;
         end
         ST_HDR1: begin
            w_out       = c_HDR1_SYM;
            w_out_valid = 1'b1;
            w_state_nxt = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (io_bus.i_din_valid) begin
               w_accept    = 1'b1;
               w_out       = io_bus.i_din ^ w_key_sym;
               w_out_valid = 1'b1;
               if (r_cnt == c_LAST) begin
`ifdef ENC_FRAME_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_DONE;
`endif
               end
            end
         end
`ifdef ENC_FRAME_PARITY_EN
         ST_PARITY: begin
            w_out       = r_parity;
            w_out_valid = 1'b1;
            w_state_nxt = ST_DONE;
         end
`endif
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // din_ready/busy follow the next state so they line up with the state itself
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_out       <= IDLE_SYM;
         r_out_valid <= 1'b0;
         r_din_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_load) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_out       <= w_out;
         r_out_valid <= w_out_valid;
         r_din_ready <= (w_state_nxt == ST_PAYLOAD);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_done      <= w_done;
      end
   end

`ifdef ENC_FRAME_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_parity <= '0;
      end else if (w_load) begin
         r_parity <= '0;
      end else if (w_accept) begin
         r_parity <= r_parity ^ w_out;
      end
   end
`endif

   assign io_bus.o_out       = r_out;
   assign io_bus.o_out_valid = r_out_valid;
   assign io_bus.o_din_ready = r_din_ready;
   assign io_bus.o_busy      = r_busy;
   assign io_bus.o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_enc_frame_tx.sv
// +----------------------------------------------------------------------+
// | tb_enc_frame_tx : directed bench, 4- and 8-symbol framer instances.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_enc_frame_tx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   enc_frame_tx_if b4 ();
   enc_frame_tx_if b8 ();

   logic       t_sel       = 1'b0;
   logic       t_start     = 1'b0;
   logic       t_din_valid = 1'b0;
   logic [7:0] t_key       = 8'h00;
   logic [1:0] t_din       = 2'b00;

   assign b4.i_start     = t_start & ~t_sel;
   assign b4.i_key       = t_key;
   assign b4.i_din       = t_din;
   assign b4.i_din_valid = t_din_valid & ~t_sel;
   assign b8.i_start     = t_start & t_sel;
   assign b8.i_key       = t_key;
   assign b8.i_din       = t_din;
   assign b8.i_din_valid = t_din_valid & t_sel;

   enc_frame_tx #(.PAYLOAD_LEN(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io_bus(b4.slave));
   enc_frame_tx #(.PAYLOAD_LEN(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .io_bus(b8.slave));

   logic       w_ov, w_rdy, w_busy, w_done;
   logic [1:0] w_out;
   assign w_ov   = t_sel ? b8.o_out_valid : b4.o_out_valid;
   assign w_rdy  = t_sel ? b8.o_din_ready : b4.o_din_ready;
   assign w_busy = t_sel ? b8.o_busy      : b4.o_busy;
   assign w_done = t_sel ? b8.o_done      : b4.o_done;
   assign w_out  = t_sel ? b8.o_out       : b4.o_out;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] din_tab [8];
   logic [1:0] obs [$];
   logic [1:0] exp_q [$];
   int         gap_cnt, gap_bad, done_cnt, done_c, last_v;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic run_frame(input logic [7:0] k, input int n_pay, input int stall_after,
                            input int stall_len, input int start_cycles);
      int acc;
      int stall_left;
      obs.delete();
      gap_cnt = 0; gap_bad = 0; done_cnt = 0; done_c = -1; last_v = -1;
      acc = 0; stall_left = stall_len;
      t_key = k; t_start = 1'b1; t_din_valid = 1'b0;
      for (int cyc = 0; cyc < 80 && done_c < 0; cyc++) begin
         @(posedge clk); #1;
         if (cyc >= start_cycles - 1) t_start = 1'b0;
         if (w_ov) begin
            obs.push_back(w_out);
            last_v = cyc;
         end else if (obs.size() > 0 && !w_done) begin
            gap_cnt++;
            if (w_out !== 2'b11) gap_bad++;
         end
         if (w_done) begin
            done_cnt++;
            done_c = cyc;
         end
         if (w_rdy && acc == stall_after && stall_left > 0) begin
            t_din_valid = 1'b0;
            stall_left--;
         end else if (w_rdy && acc < n_pay) begin
            t_din = din_tab[acc];
            t_din_valid = 1'b1;
            acc++;
         end else begin
            t_din_valid = 1'b0;
         end
      end
      t_start = 1'b0;
      t_din_valid = 1'b0;
   endtask

   task automatic check_frame(input string tag, input int exp_gap);
      chk({tag, "_done_seen"}, 32'(done_c >= 0), 1);
      chk({tag, "_done_after_last"}, 32'(done_c), 32'(last_v + 1));
      chk({tag, "_nsym"}, 32'(obs.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
         chk($sformatf("%s_sym%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
      chk({tag, "_gap"}, 32'(gap_cnt), 32'(exp_gap));
      chk({tag, "_gap_idle"}, 32'(gap_bad), 0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(w_done), 0);
      chk({tag, "_busy_end"}, 32'(w_busy), 0);
   endtask

   initial begin
      int cyc;
      int n_d, n_v, n_b;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("rst_out4",  32'(b4.o_out), 32'h3);
         chk("rst_ov4",   32'(b4.o_out_valid), 0);
         chk("rst_busy4", 32'(b4.o_busy), 0);
         chk("rst_rdy4",  32'(b4.o_din_ready), 0);
         chk("rst_out8",  32'(b8.o_out), 32'h3);
         chk("rst_busy8", 32'(b8.o_busy), 0);
      end

      // start held through HDR0/HDR1 must not restart the frame
      t_sel = 1'b0;
      din_tab = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      run_frame(8'hB4, 4, -1, 0, 3);
      exp_q = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
`ifdef ENC_FRAME_PARITY_EN
      exp_q.push_back(2'b00);
`endif
      check_frame("frameA", 0);
      chk("frameA_done_cnt", 32'(done_cnt), 1);

      din_tab = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
      run_frame(8'h1E, 4, 2, 5, 1);
      exp_q = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10};
`ifdef ENC_FRAME_PARITY_EN
      exp_q.push_back(2'b10);
`endif
      check_frame("stall", 5);

      t_sel = 1'b1;
      din_tab = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      run_frame(8'hB4, 8, -1, 0, 1);
      exp_q = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
`ifdef ENC_FRAME_PARITY_EN
      exp_q.push_back(2'b00);
`endif
      check_frame("wrap8", 0);

      // reset in the middle of the payload
      t_sel = 1'b0;
      t_key = 8'hB4;
      t_start = 1'b1;
      @(posedge clk); #1;
      t_start = 1'b0;
      cyc = 0;
      while (!w_rdy && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("mid_reach_payload", 32'(w_rdy), 1);
      t_din = 2'b01;
      t_din_valid = 1'b1;
      @(posedge clk); #1;
      t_din_valid = 1'b0;
      chk("mid_first_ov",  32'(w_ov), 1);
      chk("mid_first_sym", 32'(w_out), 32'h1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_busy", 32'(w_busy), 0);
      chk("mid_rst_ov",   32'(w_ov), 0);
      chk("mid_rst_out",  32'(w_out), 32'h3);
      chk("mid_rst_rdy",  32'(w_rdy), 0);
      chk("mid_rst_done", 32'(w_done), 0);
      rst_n = 1'b1;
      n_d = 0; n_v = 0; n_b = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (w_done) n_d++;
         if (w_ov)   n_v++;
         if (w_busy) n_b++;
      end
      chk("post_rst_done", 32'(n_d), 0);
      chk("post_rst_ov",   32'(n_v), 0);
      chk("post_rst_busy", 32'(n_b), 0);

      din_tab = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      run_frame(8'hB4, 4, -1, 0, 1);
      exp_q = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
`ifdef ENC_FRAME_PARITY_EN
      exp_q.push_back(2'b00);
`endif
      check_frame("after_rst", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/enc_frame_tx.md
ENC_FRAME_TX -- requirements
Module: enc_frame_tx

Interface
REQ-001 Parameter PAYLOAD_LEN, default 8, is the number of payload symbols per frame (legal 1..255).
REQ-002 Parameter IDLE_SYM, default 2'b11, is the symbol driven on out while no frame is in flight.
REQ-003 clock  input  1  single clock, all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clock.
REQ-005 start  input  1  request a new frame; honoured only in IDLE.
REQ-006 key  input  8  cipher key, latched on accepted start.
REQ-007 din  input  2  plaintext symbol.
REQ-008 din_valid  input  1  din holds a valid symbol.
REQ-009 din_ready  output  1  block accepts din this cycle.
REQ-010 out  output  2  framed symbol stream to the downstream output stage.
REQ-011 out_valid  output  1  out carries a frame symbol.
REQ-012 busy  output  1  frame in progress (state not IDLE).
REQ-013 done  output  1  one-cycle pulse after last frame symbol.

Function
REQ-014 States IDLE, HDR0, HDR1, PAYLOAD, PARITY (macro-dependent), DONE, held in a registered state variable.
REQ-015 IDLE: out=IDLE_SYM, out_valid=0, din_ready=0; start=1 latches key into key_reg, clears symbol counter and parity accumulator, next HDR0.
REQ-016 HDR0: out=2'b00, out_valid=1 for exactly one cycle, next HDR1.
REQ-017 HDR1: out=2'b01, out_valid=1 for exactly one cycle, next PAYLOAD.
REQ-018 PAYLOAD: din_ready=1; on din_valid=1, out=din XOR key_reg[1:0], out_valid=1, key_reg rotates right by 2, counter increments.
REQ-019 PAYLOAD with din_valid=0: out=IDLE_SYM, out_valid=0, no key rotation, counter held (stall, unbounded).
REQ-020 Accepted symbol with counter == PAYLOAD_LEN-1 ends payload: next PARITY if enabled, else DONE.
REQ-021 Key rotation wraps every 4 symbols; symbol k uses key bits [2(k mod 4)+1 : 2(k mod 4)].
REQ-022 DONE: out=IDLE_SYM, out_valid=0, done=1 for one cycle, next IDLE.
REQ-023 All outputs are registered; out/out_valid appear one cycle after the state/handshake that produces them.
REQ-024 start asserted outside IDLE is ignored; a frame is never aborted except by reset.
REQ-025 start held high continuously yields back-to-back frames separated by DONE and one IDLE cycle.
REQ-026 Symbol counter width is 8 bits; no overflow is reachable for legal PAYLOAD_LEN.

Reset
REQ-027 reset=0 at a rising edge forces IDLE, out=IDLE_SYM, out_valid=0, din_ready=0, busy=0, done=0, key_reg=0, counter=0, parity=0.
REQ-028 Reset mid-frame discards the frame; no partial DONE pulse is produced.

Configuration
REQ-029 Macro ENC_FRAME_PARITY_EN defined: after payload, PARITY state emits XOR of all ciphertext symbols of the frame for one cycle with out_valid=1, then DONE.
REQ-030 Macro ENC_FRAME_PARITY_EN undefined: PARITY state and accumulator are absent; PAYLOAD goes directly to DONE.

Structure
REQ-031 Shared package holds the state encoding, header symbols 2'b00/2'b01, and IDLE_SYM default.
REQ-032 One sub-module, key_rotator (8-bit load/rotate-by-2 register exposing current 2-bit key symbol), is instantiated; everything else is flat.

Verification
REQ-033 Reset low 3 cycles then high -> out=2'b11, out_valid=0, busy=0 every cycle until start.
REQ-034 key=8'hB4, start, PAYLOAD_LEN=4, din 00,01,10,11 streamed -> out 00,01 then 00,00,01,01, done pulse one cycle after.
REQ-035 PAYLOAD_LEN=8, key=8'hB4, din=2'b00 constant -> ciphertext 00,01,11,10 repeated twice (key wrap).
REQ-036 din_valid low 5 cycles mid-payload -> out_valid=0, out=2'b11, counter and key frozen; stream resumes at correct key symbol.
REQ-037 ENC_FRAME_PARITY_EN with REQ-034 stimulus -> extra symbol 2'b00 after payload, then done.
REQ-038 reset low during PAYLOAD, start during HDR1 -> immediate IDLE, no done; mid-frame start has no effect.
